// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data memory arbiter
package dmem_arb_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Grant identifiers
  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DBG = 1'b1;

  // Legal memory latency range; the counter is 4 bits wide
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;

  function automatic logic lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - requester picker; DMEM_ARB_RR_EN selects round-robin on conflict
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic cpu_req_i,
  input  logic dbg_req_i,
`ifdef DMEM_ARB_RR_EN
  input  logic last_gnt_i,
`endif
  output logic gnt_o
);

  // Choose the winner; the caller only uses the result when some request is up
  always_comb begin
    gnt_o = GNT_CPU;
`ifdef DMEM_ARB_RR_EN
    if (cpu_req_i && dbg_req_i) begin
      gnt_o = (last_gnt_i == GNT_CPU) ? GNT_DBG : GNT_CPU;
    end else if (dbg_req_i) begin
      gnt_o = GNT_DBG;
    end
`else
    if (!cpu_req_i && dbg_req_i) begin
      gnt_o = GNT_DBG;
    end
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data memory arbiter (CPU vs debug/loader); build option DMEM_ARB_RR_EN
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_ack_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  // Out-of-range latencies collapse to a single-cycle access
  localparam logic [3:0]        CNT_INIT   = lat_ok(MEM_LAT) ? 4'(MEM_LAT - 1) : 4'd0;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d, pick_gnt;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              access;
`ifdef DMEM_ARB_RR_EN
  logic              last_q, last_d;
`endif

  dmem_arb_pick u_pick (
    .cpu_req_i (cpu_req_i),
    .dbg_req_i (dbg_req_i),
`ifdef DMEM_ARB_RR_EN
    .last_gnt_i(last_q),
`endif
    .gnt_o     (pick_gnt)
  );

  // State, request copy, counter and read-data registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= 4'd0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Last-grant register; starts at DBG so the CPU wins the first conflict
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= GNT_DBG;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Next-state logic: grant in IDLE, count down in ACCESS, single ack cycle in RESP
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
`ifdef DMEM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i && (cpu_req_i || dbg_req_i)) begin
          gnt_d   = pick_gnt;
          we_d    = (pick_gnt == GNT_DBG) ? dbg_we_i : cpu_we_i;
          addr_d  = ((pick_gnt == GNT_DBG) ? dbg_addr_i : cpu_addr_i) & ALIGN_MASK;
          wdata_d = (pick_gnt == GNT_DBG) ? dbg_wdata_i : cpu_wdata_i;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
`ifdef DMEM_ARB_RR_EN
          last_d  = pick_gnt;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (gnt_q == GNT_DBG) begin
            dbg_rdata_d = mem_rdata_i;
          end else begin
            cpu_rdata_d = mem_rdata_i;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The write strobe is confined to the final access cycle so a write lands exactly once
  assign access      = (state_q == ACCESS);
  assign mem_en_o    = access;
  assign mem_we_o    = access & we_q & (cnt_q == 4'd0);
  assign mem_addr_o  = access ? addr_q : '0;
  assign mem_wdata_o = access ? wdata_q : '0;
  assign cpu_ack_o   = (state_q == RESP) & (gnt_q == GNT_CPU);
  assign dbg_ack_o   = (state_q == RESP) & (gnt_q == GNT_DBG);
  assign cpu_rdata_o = cpu_rdata_q;
  assign dbg_rdata_o = dbg_rdata_q;
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter (default build or DMEM_ARB_RR_EN)
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst, start, mem_clr;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, cpu_stall, dbg_ack, mem_en, mem_we;
  logic [31:0] mem [0:15];

  logic        l1_req, l15_req;
  logic [31:0] l1_rdata, l1_drd, l1_addr, l1_wdata, l15_rdata, l15_drd, l15_addr, l15_wdata;
  logic        l1_ack, l1_stall, l1_dack, l1_en, l1_we;
  logic        l15_ack, l15_stall, l15_dack, l15_en, l15_we;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int we_pos = 0;
  int en_run = 0;
  int stall_cnt = 0;
  int side_err = 0;
  logic last_m = GNT_DBG;

  typedef struct {
    logic        port;
    bit          chk;
    logic [31:0] data;
    int          lat;
    int          wr;
    bit          hold;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_stall_o(cpu_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_rdata_o(dbg_rdata), .dbg_ack_o(dbg_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .cpu_req_i(l1_req), .cpu_we_i(1'b0), .cpu_addr_i(32'h08), .cpu_wdata_i(32'h0),
    .cpu_rdata_o(l1_rdata), .cpu_ack_o(l1_ack), .cpu_stall_o(l1_stall),
    .dbg_req_i(1'b0), .dbg_we_i(1'b0), .dbg_addr_i(32'h0), .dbg_wdata_i(32'h0),
    .dbg_rdata_o(l1_drd), .dbg_ack_o(l1_dack),
    .mem_en_o(l1_en), .mem_we_o(l1_we), .mem_addr_o(l1_addr), .mem_wdata_o(l1_wdata),
    .mem_rdata_i(32'h0000_1111)
  );

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(15)) u_lat15 (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .cpu_req_i(l15_req), .cpu_we_i(1'b0), .cpu_addr_i(32'h08), .cpu_wdata_i(32'h0),
    .cpu_rdata_o(l15_rdata), .cpu_ack_o(l15_ack), .cpu_stall_o(l15_stall),
    .dbg_req_i(1'b0), .dbg_we_i(1'b0), .dbg_addr_i(32'h0), .dbg_wdata_i(32'h0),
    .dbg_rdata_o(l15_drd), .dbg_ack_o(l15_dack),
    .mem_en_o(l15_en), .mem_we_o(l15_we), .mem_addr_o(l15_addr), .mem_wdata_o(l15_wdata),
    .mem_rdata_i(32'h0000_FFFF)
  );

  // Memory model: combinational read, write on the strobed cycle
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  // Write-strobe counter and position of the strobe within the access window
  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      we_pos <= en_run + 1;
    end
    if (mem_en) en_run <= en_run + 1;
    else        en_run <= 0;
  end

  always @(negedge clk) begin
    if (cpu_stall) stall_cnt <= stall_cnt + 1;
    if (l1_we || l1_dack || l1_drd !== 32'h0 || l1_stall !== (l1_req & ~l1_ack) ||
        (l1_en && (l1_addr !== 32'h08 || l1_wdata !== 32'h0))) side_err <= side_err + 1;
    if (l15_we || l15_dack || l15_drd !== 32'h0 || l15_stall !== (l15_req & ~l15_ack) ||
        (l15_en && (l15_addr !== 32'h08 || l15_wdata !== 32'h0))) side_err <= side_err + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic model_pick(input logic c, input logic d);
`ifdef DMEM_ARB_RR_EN
    if (c && d) return (last_m == GNT_CPU) ? GNT_DBG : GNT_CPU;
`endif
    return c ? GNT_CPU : GNT_DBG;
  endfunction

  function automatic void push(input logic port, input bit chk, input logic [31:0] data,
                               input int lat, input int wr, input bit hold);
    exp_t e;
    e.port = port; e.chk = chk; e.data = data; e.lat = lat; e.wr = wr; e.hold = hold;
    sb.push_back(e);
  endfunction

  task automatic expect_ack(input string name, input int budget);
    exp_t e;
    int n, we0;
    bit seen;
    logic [31:0] rd;
    e = sb.pop_front();
    we0 = we_cnt; n = 0; seen = 0;
    while (!seen && n < budget) begin
      tick(); n++;
      if ((e.port == GNT_CPU) ? cpu_ack : dbg_ack) seen = 1;
    end
    last_m = e.port;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s timeout: no ack within %0d cycles", name, budget);
    end else begin
      rd = (e.port == GNT_CPU) ? cpu_rdata : dbg_rdata;
      tests++;
      if (n !== e.lat) begin
        fails++; $display("FAIL %s latency: got %0d expected %0d", name, n, e.lat);
      end
      if (e.chk) begin
        tests++;
        if (rd !== e.data) begin
          fails++; $display("FAIL %s rdata: got %h expected %h", name, rd, e.data);
        end
      end
      tests++;
      if ((we_cnt - we0) !== e.wr) begin
        fails++; $display("FAIL %s we pulses: got %0d expected %0d", name, we_cnt - we0, e.wr);
      end
      if (e.wr == 1) begin
        tests++;
        if (we_pos !== LAT) begin
          fails++; $display("FAIL %s we position: got %0d expected %0d", name, we_pos, LAT);
        end
      end
      if (!e.hold) begin
        if (e.port == GNT_CPU) cpu_req = 1'b0;
        else                   dbg_req = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    last_m = GNT_DBG;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1;
    idle(2);
    tests++;
    if ({mem_en, mem_we, cpu_ack, dbg_ack, cpu_stall} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_en, mem_we, cpu_ack, dbg_ack, cpu_stall});
    end
    tests++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      fails++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata});
    end
    tests++;
    if ({cpu_rdata, dbg_rdata} !== 64'h0) begin
      fails++; $display("FAIL reset_rdata: got %h expected 0", {cpu_rdata, dbg_rdata});
    end
    mem_clr = 1'b0; rst = 1'b0;
    idle(1);
    tests++;
    if (dut.state_q !== IDLE) begin
      fails++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
    end
  endtask

  task automatic test_cpu_write();
    start = 1'b1;
    idle(2);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h04; cpu_wdata = 32'h1234_5678;
    push(GNT_CPU, 1'b0, 32'h0, LAT + 1, 1, 1'b0);
    expect_ack("cpu_write", 20);
    tests++;
    if (mem[1] !== 32'h1234_5678) begin
      fails++; $display("FAIL cpu_write mem[1]: got %h expected 12345678", mem[1]);
    end
  endtask

  task automatic test_cpu_read();
    int s0;
    idle(2);
    s0 = stall_cnt;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h04;
    push(GNT_CPU, 1'b1, 32'h1234_5678, LAT + 1, 0, 1'b0);
    expect_ack("cpu_read", 20);
    tests++;
    if ((stall_cnt - s0) !== LAT + 1) begin
      fails++; $display("FAIL cpu_read stall cycles: got %0d expected %0d", stall_cnt - s0, LAT + 1);
    end
  endtask

  task automatic test_conflict();
    logic w;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      idle(2);
      w = model_pick(1'b1, 1'b1);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h14;
      push(w, 1'b1, (w == GNT_CPU) ? 32'hA5A5_0004 : 32'hA5A5_0005, LAT + 1, 0, 1'b0);
      push(~w, 1'b1, (w == GNT_CPU) ? 32'hA5A5_0005 : 32'hA5A5_0004, LAT + 2, 0, 1'b0);
      expect_ack("conflict_first", 20);
      expect_ack("conflict_second", 20);
    end
  endtask

  task automatic test_start_gate();
    bit bad;
    idle(2);
    start = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h00; dbg_wdata = 32'h5;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_en || dbg_ack || cpu_ack) bad = 1;
    end
    tests++;
    if (bad) begin
      fails++; $display("FAIL start_gate: got grant expected none");
    end
    start = 1'b1;
    push(GNT_DBG, 1'b0, 32'h0, LAT + 1, 1, 1'b0);
    expect_ack("dbg_write", 20);
    tests++;
    if (mem[0] !== 32'h5) begin
      fails++; $display("FAIL dbg_write mem[0]: got %h expected 00000005", mem[0]);
    end
  endtask

  task automatic test_reset_mid_access();
    int we0;
    bit acked;
    idle(2);
    we0 = we_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0C; cpu_wdata = 32'hCAFE_F00D;
    tick();
    tests++;
    if (mem_en !== 1'b1) begin
      fails++; $display("FAIL rst_mid access start: got %b expected 1", mem_en);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (mem_en !== 1'b0 || dut.state_q !== IDLE) begin
      fails++; $display("FAIL rst_mid abort: got en=%b state=%0d expected en=0 state=%0d", mem_en, dut.state_q, IDLE);
    end
    cpu_req = 1'b0;
    idle(2);
    rst = 1'b0;
    last_m = GNT_DBG;
    acked = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ack || dbg_ack) acked = 1;
    end
    tests++;
    if (acked || (we_cnt - we0) !== 0) begin
      fails++; $display("FAIL rst_mid no_ack_no_write: got ack=%b we=%0d expected ack=0 we=0", acked, we_cnt - we0);
    end
    tests++;
    if (mem[3] !== 32'hA5A5_0003) begin
      fails++; $display("FAIL rst_mid mem[3]: got %h expected a5a50003", mem[3]);
    end
  endtask

  task automatic test_back_to_back();
    idle(2);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h08;
    push(GNT_CPU, 1'b1, 32'hA5A5_0002, LAT + 1, 0, 1'b1);
    push(GNT_CPU, 1'b1, 32'hA5A5_0002, LAT + 2, 0, 1'b1);
    push(GNT_CPU, 1'b1, 32'hA5A5_0002, LAT + 2, 0, 1'b0);
    for (int i = 0; i < 3; i++) expect_ack("back_to_back", 20);
  endtask

  task automatic test_lat_builds();
    int q1[$];
    int q15[$];
    int n, e;
    idle(2);
    q1 = '{2, 5, 8};
    q15 = '{16, 33, 50};
    l1_req = 1'b1; l15_req = 1'b1;
    n = 0;
    while ((q1.size() > 0 || q15.size() > 0) && n < 80) begin
      tick(); n++;
      if (l1_ack) begin
        tests++;
        if (q1.size() == 0) begin
          fails++; $display("FAIL lat1 extra ack: got ack at %0d expected none", n);
        end else begin
          e = q1.pop_front();
          if (n !== e || l1_rdata !== 32'h0000_1111) begin
            fails++; $display("FAIL lat1 ack: got t=%0d d=%h expected t=%0d d=00001111", n, l1_rdata, e);
          end
          if (q1.size() == 0) l1_req = 1'b0;
        end
      end
      if (l15_ack) begin
        tests++;
        if (q15.size() == 0) begin
          fails++; $display("FAIL lat15 extra ack: got ack at %0d expected none", n);
        end else begin
          e = q15.pop_front();
          if (n !== e || l15_rdata !== 32'h0000_FFFF) begin
            fails++; $display("FAIL lat15 ack: got t=%0d d=%h expected t=%0d d=0000ffff", n, l15_rdata, e);
          end
          if (q15.size() == 0) l15_req = 1'b0;
        end
      end
    end
    tests++;
    if (q1.size() != 0 || q15.size() != 0) begin
      fails++; $display("FAIL lat builds timeout: got %0d/%0d pending expected 0/0", q1.size(), q15.size());
    end
    idle(4);
    tests++;
    if (side_err !== 0) begin
      fails++; $display("FAIL lat builds side outputs: got %0d bad cycles expected 0", side_err);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_clr = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    l1_req = 1'b0; l15_req = 1'b0;
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_conflict();
    test_start_gate();
    test_reset_mid_access();
    test_back_to_back();
    test_lat_builds();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
